accum_alu: RTL

//   Parametrised, registered accumulator ALU. Successor to the 4-bit combinational ALU.

---
 rtl/accum_alu.sv | 90 +++++++++
 1 files changed

// File: rtl/accum_alu.sv
// accum_alu: registered accumulator ALU with carry/zero flags and a shift-and-add multiply
module accum_alu #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             use_acc,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] acc_out,
    output logic             cout,
    output logic             zero,
    output logic             out_valid,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t state, state_nxt;
    logic [CW-1:0]      count;
    logic [2*WIDTH-1:0] mcand, product, prod_nxt;
    logic [WIDTH-1:0]   mplier, aop;
    logic [WIDTH:0]     add_r, sub_r, res;
    logic               accept, mul_go, done;
    assign aop      = use_acc ? acc_out : A;
    assign in_ready = state == IDLE;
    assign busy     = state == BUSY;
    assign accept   = in_valid && in_ready;
    assign mul_go   = accept && op == 3'd7;
    assign done     = busy && count == CW'(WIDTH - 1);
    assign prod_nxt = product + (mplier[0] ? mcand : '0);
    // single-cycle result: carry-in for ADDC is the stored cout, SUB carry means no borrow
    always_comb begin
        add_r = {1'b0, aop} + {1'b0, B} + {{WIDTH{1'b0}}, op == 3'd5 && cout};
        sub_r = {1'b0, aop} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        res   = op == 3'd1 || op == 3'd5 ? add_r :
                op == 3'd4 ? sub_r :
                op == 3'd2 ? {1'b0, aop & B} :
                op == 3'd3 ? {1'b0, ~aop} :
                op == 3'd6 ? {1'b0, aop ^ B} : {1'b0, aop};
    end
    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    // multiply sequencing: leave BUSY on the last shift-and-add step
    always_comb begin
        state_nxt = state;
        if (state == IDLE && mul_go) state_nxt = BUSY;
        if (done)                    state_nxt = IDLE;
    end
    // accumulator, flags, completion pulse and multiplier datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_out   <= '0;
            cout      <= 1'b0;
            zero      <= 1'b1;
            out_valid <= 1'b0;
            count     <= '0;
            mcand     <= '0;
            mplier    <= '0;
            product   <= '0;
        end else begin
            out_valid <= (accept && !mul_go) || done;
            if (accept && !mul_go) begin
                acc_out <= res[WIDTH-1:0];
                cout    <= res[WIDTH];
                zero    <= res[WIDTH-1:0] == '0;
            end else if (done) begin
                acc_out <= prod_nxt[WIDTH-1:0];
                cout    <= |prod_nxt[2*WIDTH-1:WIDTH];
                zero    <= prod_nxt[WIDTH-1:0] == '0;
            end
            if (mul_go) begin
                mcand   <= {{WIDTH{1'b0}}, aop};
                mplier  <= B;
                product <= '0;
                count   <= '0;
            end else if (busy) begin
                product <= prod_nxt;
                mcand   <= mcand << 1;
                mplier  <= mplier >> 1;
                count   <= count + CW'(1);
            end
        end
    end
endmodule
